// File: rtl/gate_bank_pipe_if.sv
// gate_bank_pipe_if: input offer channel and output entry channel for gate_bank_pipe.
// master is the producer/consumer side, slave is the gate bank itself.
interface gate_bank_pipe_if #(
    parameter int WIDTH  = 5,
    parameter int FANOUT = 2
);
    logic                      in_valid;
    logic                      in_ready;
    logic [WIDTH-1:0]          in_data;
    logic [1:0]                in_mode;
    logic                      out_valid;
    logic                      out_ready;
    logic [WIDTH*FANOUT-1:0]   out_data;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/gate_bank_pipe.sv
// gate_bank_pipe: WIDTH parallel gates (NOT / BUF / drive-0 / drive-1) whose
// results are queued in a DEPTH-entry FIFO and presented as FANOUT identical copies.
// Optional macro GATE_BANK_PIPE_PARITY_EN adds out_parity (XOR of the head entry).
// Only one copy is stored per entry; the copies are replicated at the output,
// which keeps them bit-identical by construction.
module gate_bank_pipe #(
    parameter int WIDTH  = 5,
    parameter int FANOUT = 2,
    parameter int DEPTH  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    gate_bank_pipe_if.slave    bus,
`ifdef GATE_BANK_PIPE_PARITY_EN
    output logic               out_parity,
`endif
    output logic [15:0]        xfer_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      occ;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] gate_res;
    logic [WIDTH-1:0] head;

    // Handshake flags come from occupancy only, so in_ready never depends on out_ready.
    assign bus.in_ready  = (occ < FULL_CNT);
    assign bus.out_valid = (occ != '0);
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;

    // Gate function applied to the whole lane group at once.
    always_comb begin
        gate_res = '0;
        unique case (bus.in_mode)
            2'b00:   gate_res = ~bus.in_data;
            2'b01:   gate_res = bus.in_data;
            2'b10:   gate_res = '0;
            default: gate_res = '1;
        endcase
    end

    // Entry storage; not reset, masked at the output while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= gate_res;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Completed output transfers, free-running 16-bit wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_count <= '0;
        end else if (pop) begin
            xfer_count <= xfer_count + 1'b1;
        end
    end

    // Head entry, forced to zero when empty so stale storage never escapes.
    always_comb begin
        head = '0;
        if (bus.out_valid) begin
            head = mem[rd_ptr];
        end
    end

    assign bus.out_data = {FANOUT{head}};

`ifdef GATE_BANK_PIPE_PARITY_EN
    assign out_parity = ^head;
`endif

endmodule

// File: tb/tb_gate_bank_pipe.sv
// tb_gate_bank_pipe: directed scenarios plus randomized traffic against a
// queue-based reference model of the gate bank FIFO.
module tb_gate_bank_pipe;
    localparam int WIDTH  = 5;
    localparam int FANOUT = 2;
    localparam int DEPTH  = 2;
    localparam int OW     = WIDTH * FANOUT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] xfer_count;
`ifdef GATE_BANK_PIPE_PARITY_EN
    logic        out_parity;
`endif

    gate_bank_pipe_if #(.WIDTH(WIDTH), .FANOUT(FANOUT)) bus ();

    gate_bank_pipe #(.WIDTH(WIDTH), .FANOUT(FANOUT), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
`ifdef GATE_BANK_PIPE_PARITY_EN
        .out_parity (out_parity),
`endif
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    logic [OW-1:0] q[$];
    logic [15:0]   m_xfer;
    int            n_vec = 0;
    int            n_err = 0;

    // Count one comparison and report it if it disagrees.
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference gate: whole-word behaviour, replicated FANOUT times.
    function automatic logic [OW-1:0] ref_entry(input logic [WIDTH-1:0] d, input logic [1:0] m);
        logic [WIDTH-1:0] g;
        logic [OW-1:0]    r;
        case (m)
            2'd0:    g = ~d;
            2'd1:    g = d;
            2'd2:    g = '0;
            default: g = '1;
        endcase
        r = '0;
        for (int k = 0; k < FANOUT; k++) r[k*WIDTH +: WIDTH] = g;
        return r;
    endfunction

    task automatic check_outputs();
        logic [OW-1:0]    h;
        logic [WIDTH-1:0] c0;
        h = (q.size() > 0) ? q[0] : '0;
        c0 = h[WIDTH-1:0];
        chk("in_ready",   64'(bus.in_ready),  64'(q.size() < DEPTH));
        chk("out_valid",  64'(bus.out_valid), 64'(q.size() > 0));
        chk("out_data",   64'(bus.out_data),  64'(h));
        chk("xfer_count", 64'(xfer_count),    64'(m_xfer));
`ifdef GATE_BANK_PIPE_PARITY_EN
        chk("out_parity", 64'(out_parity),    64'(^c0));
`else
        if (c0 === 'x) chk("head_known", 64'(c0), 64'(h[WIDTH-1:0]));
`endif
    endtask

    // One clock: optional check at the low phase, then model update at the edge.
    task automatic cycle(input bit do_chk);
        bit            push;
        bit            pop;
        logic [OW-1:0] ent;
        logic [OW-1:0] dummy;
        if (do_chk) check_outputs();
        push = bus.in_valid && (q.size() < DEPTH);
        pop  = bus.out_ready && (q.size() > 0);
        ent  = ref_entry(bus.in_data, bus.in_mode);
        @(posedge clk);
        if (pop) begin
            dummy = q.pop_front();
            m_xfer = m_xfer + 16'd1;
        end
        if (push) q.push_back(ent);
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [WIDTH-1:0] d, input logic [1:0] m, input bit r);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_mode   = m;
        bus.out_ready = r;
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        m_xfer = '0;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("rst_out_data",  64'(bus.out_data),  64'd0);
        chk("rst_xfer",      64'(xfer_count),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int guard;
        drive(1'b0, '0, 2'd0, 1'b0);
        rst_n  = 1'b1;
        m_xfer = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check_outputs();
        @(negedge clk);

        // NOT of 10110, single entry straight through
        rst_n = 1'b1;
        drive(1'b1, 5'b10110, 2'd0, 1'b1);
        cycle(1);
        drive(1'b0, '0, 2'd0, 1'b1);
        chk("r033_valid", 64'(bus.out_valid), 64'd1);
        chk("r033_data",  64'(bus.out_data),  64'h129);
        chk("r033_xfer0", 64'(xfer_count),    64'd0);
        cycle(1);
        chk("r033_xfer1", 64'(xfer_count),    64'd1);

        // Fill to full with BUF 1,2,3 then drain in order
        drive(1'b1, 5'h01, 2'd1, 1'b0);
        cycle(1);
        bus.in_data = 5'h02;
        cycle(1);
        chk("r034_full", 64'(bus.in_ready), 64'd0);
        bus.in_data = 5'h03;
        cycle(1);
        bus.out_ready = 1'b1;
        chk("r034_h1", 64'(bus.out_data), 64'h021);
        cycle(1);
        chk("r034_h2", 64'(bus.out_data), 64'h042);
        cycle(1);
        bus.in_valid = 1'b0;
        chk("r034_h3", 64'(bus.out_data), 64'h063);
        cycle(1);
        cycle(1);

        // drive-0 / drive-1
        drive(1'b1, 5'h15, 2'd2, 1'b1);
        cycle(1);
        chk("r035_d0", 64'(bus.out_data), 64'h000);
        bus.in_mode = 2'd3;
        cycle(1);
        chk("r035_d1", 64'(bus.out_data), 64'h3FF);
        bus.in_valid = 1'b0;
        cycle(1);

        // One entry buffered, push and pop together
        drive(1'b1, 5'h0A, 2'd1, 1'b0);
        cycle(1);
        drive(1'b1, 5'h11, 2'd1, 1'b1);
        cycle(1);
        chk("r036_valid", 64'(bus.out_valid), 64'd1);
        chk("r036_ready", 64'(bus.in_ready),  64'd1);
        chk("r036_data",  64'(bus.out_data),  64'h231);
        bus.in_valid = 1'b0;
        cycle(1);

`ifdef GATE_BANK_PIPE_PARITY_EN
        drive(1'b1, 5'b01001, 2'd1, 1'b0);
        cycle(1);
        chk("r038_par0", 64'(out_parity), 64'd0);
        drive(1'b0, '0, 2'd0, 1'b1);
        cycle(1);
        drive(1'b1, 5'b01011, 2'd1, 1'b0);
        cycle(1);
        chk("r038_par1", 64'(out_parity), 64'd1);
        drive(1'b0, '0, 2'd0, 1'b1);
        cycle(1);
`endif

        // Async reset with two entries buffered
        drive(1'b1, 5'h07, 2'd0, 1'b0);
        cycle(1);
        bus.in_data = 5'h19;
        cycle(1);
        bus.in_valid = 1'b0;
        async_reset();
        drive(1'b1, 5'h04, 2'd1, 1'b0);
        cycle(1);
        bus.in_valid = 1'b0;
        chk("r029_first", 64'(bus.out_data), 64'h084);
        bus.out_ready = 1'b1;
        cycle(1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            int bias;
            bias = (i / 250) % 3;
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = WIDTH'($urandom);
            bus.in_mode   = 2'($urandom);
            bus.out_ready = (bias == 0) ? ($urandom_range(0, 3) != 0)
                          : (bias == 1) ? ($urandom_range(0, 3) == 0)
                          : 1'($urandom);
            cycle(1);
        end

        // xfer_count wrap after 65536 transfers
        bus.in_valid = 1'b0;
        async_reset();
        drive(1'b1, 5'h1F, 2'd1, 1'b1);
        guard = 0;
        while (m_xfer != 16'hFFFF && guard < 70000) begin
            bus.in_data = WIDTH'($urandom);
            cycle(0);
            guard++;
        end
        chk("wrap_pre",  64'(xfer_count), 64'hFFFF);
        check_outputs();
        bus.in_valid = 1'b0;
        cycle(0);
        chk("wrap_zero", 64'(xfer_count), 64'h0000);
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
